mips_cpu_avalon_arbiter: RTL
============================

Name: mips_cpu_avalon_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter between the MIPS CPU core and the shared unified RAM. The CPU's instruction-fetch port (read-only) and data port (read/write) share one physical memory port. The block serialises their transfers, forwards the slave's waitrequest and readdata to the granted master, and stalls the other master. It also flags any transfer that stalls too long.

Parameters:
TIMEOUT_CYCLES, 1024, number of consecutive granted cycles with m_waitrequest=1 after which bus_timeout sets (minimum 2)
CNT_W, 16, width of the stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high
i_address  input  32  instruction-fetch byte address
i_read  input  1  instruction-fetch read request
i_waitrequest  output  1  stall to instruction master
i_readdata  output  32  instruction read data
d_address  input  32  data byte address
d_byteenable  input  4  data byte lanes
d_read  input  1  data read request
d_write  input  1  data write request
d_writedata  input  32  data write data
d_waitrequest  output  1  stall to data master
d_readdata  output  32  data read data
m_address  output  32  to RAM
m_byteenable  output  4  to RAM (4'b1111 for instruction fetches)
m_read  output  1  to RAM
m_write  output  1  to RAM
m_writedata  output  32  to RAM
m_waitrequest  input  1  from RAM
m_readdata  input  32  from RAM
grant  output  2  one-hot current owner: [1]=data, [0]=instr, 2'b00=idle
bus_timeout  output  1  sticky stall-timeout flag

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, grant=00, bus_timeout=0, stall counter=0, last-owner=instr. Outputs in IDLE: m_read=m_write=0, m_address=0, m_byteenable=0, m_writedata=0.
- States: IDLE, GNT_I, GNT_D (registered). Master-side outputs are combinational from state.
- IDLE:
  - Both i_waitrequest and d_waitrequest are 1; both readdata outputs are 0.
  - Next state: data request (d_read|d_write) -> GNT_D; else i_read -> GNT_I; else IDLE.
  - Both requesting: winner set by the arbitration policy (see Optional Feature).
- GNT_D:
  - m_* driven from the d_* inputs; d_waitrequest=m_waitrequest; d_readdata=m_readdata.
  - i_waitrequest=1; i_readdata=0.
- GNT_I:
  - m_address=i_address, m_read=i_read, m_write=0, m_byteenable=4'b1111.
  - i_waitrequest=m_waitrequest; i_readdata=m_readdata.
  - d_waitrequest=1; d_readdata=0.
- Completion: in a GNT state, the transfer completes when (m_read|m_write) && !m_waitrequest. Next state is always IDLE, with no back-to-back grant, so each transfer carries one arbitration cycle.
- Latency: request seen in IDLE at cycle N -> m_read/m_write at cycle N+1 -> earliest completion at N+1.
- Master drops its request while granted: abandoned, no completion; next state IDLE.
- d_read and d_write both high: forwarded as a write only (m_read=0, m_write=1).
- Stall counter:
  - Cleared in IDLE.
  - Increments each GNT cycle with m_waitrequest=1; saturates at TIMEOUT_CYCLES.
  - bus_timeout sets when the counter reaches TIMEOUT_CYCLES and stays 1 until reset.
  - The transfer is not aborted.
- Reset mid-transfer: next edge forces IDLE and deasserts m_read/m_write; the RAM-side transfer is dropped.
- last-owner register updates on each completion (used only when ARB_ROUND_ROBIN_EN is defined).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request in IDLE, the master that did not own the last completed transfer wins. After reset, data wins the first tie (last-owner=instr).
- Undefined: fixed priority, data always wins ties. The last-owner register is not built, and the instruction port may starve under continuous data requests (intended, since the core serialises).

Test Plan:
1. Reset held 2 cycles with d_write=1 and i_read=1 -> m_read=m_write=0, grant=00, both waitrequests=1, bus_timeout=0.
2. Instruction-only fetch: i_read=1, i_address=32'hBFC00000, RAM returns 32'h2402000A after 3 wait cycles -> grant=01 at N+1, m_byteenable=4'hF, i_readdata=32'h2402000A when i_waitrequest falls; IDLE on the next cycle.
3. Data byte write: d_write=1, d_byteenable=4'b0010, d_writedata=32'h0000AB00 -> m_write=1 with the same byteenable/data; d_waitrequest mirrors m_waitrequest; i_waitrequest=1 throughout.
4. Simultaneous i_read and d_read, issued twice:
   - Macro undefined: both transfers granted to data.
   - Macro defined: data is granted first, then instr; grant sequence 10,00,01.
5. Hold m_waitrequest=1 with TIMEOUT_CYCLES=8 -> bus_timeout rises on the 8th stalled cycle and stays 1 after the transfer completes and a new transfer runs.
6. Assert reset for 1 cycle in GNT_D mid-stall -> state IDLE, m_write=0 on the next cycle, stall counter and bus_timeout cleared.

Source files
------------

// File: rtl/mips_cpu_avalon_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mips_cpu_avalon_arbiter
// Description : Two-master (instruction fetch, data) to one-slave Avalon-MM
//               arbiter with a sticky stall-timeout flag. Define
//               ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise
//               data wins ties.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_cpu_avalon_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] m_address,
    output logic [3:0]  m_byteenable,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic [1:0]  grant,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_next;
    logic             r_timeout;
    logic             w_d_req;
    logic             w_pick_d;
    logic             w_active;
    logic             w_done;

    assign w_d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // High when the data master owned the most recently completed transfer.
    logic r_last_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_data <= 1'b0;
        end else if (w_done) begin
            r_last_data <= (r_state == S_GNT_D);
        end
    end

    assign w_pick_d = w_d_req & (~i_read | ~r_last_data);
`else
    assign w_pick_d = w_d_req;
`endif

    // The granted master still holding its request keeps the transfer alive.
    always_comb begin
        w_active = 1'b0;
        case (r_state)
            S_GNT_I: w_active = i_read;
            S_GNT_D: w_active = w_d_req;
            default: w_active = 1'b0;
        endcase
    end

    assign w_done = w_active & ~m_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        i_waitrequest = 1'b1;
        i_readdata    = 32'h0;
        d_waitrequest = 1'b1;
        d_readdata    = 32'h0;
        m_address     = 32'h0;
        m_byteenable  = 4'h0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_d) begin
                    w_state_next = S_GNT_D;
                end else if (i_read) begin
                    w_state_next = S_GNT_I;
                end
            end
            S_GNT_I: begin
                m_address     = i_address;
                m_read        = i_read;
                m_byteenable  = 4'hF;
                i_waitrequest = m_waitrequest;
                i_readdata    = m_readdata;
                if (!w_active || !m_waitrequest) begin
                    w_state_next = S_IDLE;
                end
            end
            S_GNT_D: begin
                m_address     = d_address;
                m_byteenable  = d_byteenable;
                m_read        = d_read & ~d_write;
                m_write       = d_write;
                m_writedata   = d_writedata;
                d_waitrequest = m_waitrequest;
                d_readdata    = m_readdata;
                if (!w_active || !m_waitrequest) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall_next = r_stall_cnt;
        if (r_state == S_IDLE) begin
            w_stall_next = '0;
        end else if (m_waitrequest && (r_stall_cnt != c_timeout)) begin
            w_stall_next = r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_next;
            if (w_stall_next == c_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign grant       = {r_state == S_GNT_D, r_state == S_GNT_I};
    assign bus_timeout = r_timeout;

endmodule

`default_nettype wire
